sram_bridge: RTL
================

SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, giving the halfword address width of the external SRAM.
REQ-002 The block SHALL have parameter LOW_FIRST, default 1: 1 = low halfword accessed first, 0 = high halfword first.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_en, input, 1, request strobe from the memory controller.
REQ-006 The block SHALL have port req_rw, input, 1, access type: 1 = write, 0 = read.
REQ-007 The block SHALL have port req_addr, input, ADDR_W, halfword address; bit 0 is ignored.
REQ-008 The block SHALL have port req_wdata, input, 32, write word.
REQ-009 The block SHALL have port req_rdata, output, 32, read word.
REQ-010 The block SHALL have port req_busy, output, 1, high while a transfer is in progress.
REQ-011 The block SHALL have port req_done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port addr, output, ADDR_W, SRAM address.
REQ-013 The block SHALL have port data, inout, 16, SRAM data bus.
REQ-014 The block SHALL have ports wre, oute and chip_en, each output, 1, SRAM write-enable, output-enable and chip-enable, all active-low.
REQ-015 The block SHALL have ports hb_mask and lb_mask, each output, 1, SRAM byte masks, active-low.

Function
REQ-016 The FSM SHALL have states IDLE, FIRST, SECOND and DONE; every output SHALL be registered.
REQ-017 The FSM SHALL accept a request only in IDLE with req_en=1; it SHALL latch req_rw, {req_addr[ADDR_W-1:1],0} and req_wdata, and go to FIRST; req_en SHALL be ignored in all other states.
REQ-018 The low halfword SHALL be at the even address and the high halfword at the even address + 1; FIRST/SECOND SHALL select the halves per LOW_FIRST.
REQ-019 During FIRST and SECOND the block SHALL set chip_en=0 and hb_mask=lb_mask=0, and drive addr with the current halfword address.
REQ-020 On a read, the block SHALL hold oute=0 and wre=1, keep data at high-Z, and capture data into the matching half of req_rdata at the end of each state.
REQ-021 On a write, the block SHALL hold oute=1 and wre=0, and drive data with the matching half of the latched word; data SHALL be high-Z in every other state.
REQ-022 In DONE the block SHALL deassert all SRAM strobes, pulse req_done=1 for exactly one cycle and return to IDLE.
REQ-023 Latency SHALL be 3 cycles: with the request accepted at edge N, req_done is high in the cycle after edge N+2.
REQ-024 req_busy SHALL be 1 in FIRST, SECOND and DONE, and 0 in IDLE.
REQ-025 req_rdata SHALL hold its value until the next read completes; writes SHALL not alter it.
REQ-026 Address wrap SHALL be avoided by construction: the even base address + 1 never overflows ADDR_W.

Reset
REQ-027 When reset=0 the block SHALL immediately enter IDLE, including mid-transfer, and abandon the transfer with no req_done.
REQ-028 Reset values SHALL be: req_rdata=0, req_busy=0, req_done=0, addr=0, wre=oute=chip_en=hb_mask=lb_mask=1, data high-Z.

Configuration
REQ-029 When macro SRAM_BRIDGE_WAIT_EN is defined, FIRST and SECOND SHALL each last 2 cycles; read data SHALL be captured at the end of the second cycle, and latency becomes 5 cycles.
REQ-030 When SRAM_BRIDGE_WAIT_EN is undefined, FIRST and SECOND SHALL each last 1 cycle, per REQ-023.

Verification
REQ-031 Write 0xDEADBEEF at addr 0x00010, LOW_FIRST=1 -> data=0xBEEF with addr=0x00010, then data=0xDEAD with addr=0x00011, wre=0 each cycle; req_done 3 cycles after accept.
REQ-032 Read of addr 0x00011 with SRAM model holding 0x1234@0x00010 and 0xABCD@0x00011 -> addr bit 0 ignored; req_rdata=0xABCD1234 with req_done.
REQ-033 req_en held at 1 continuously -> new request accepted only in IDLE, so one accept every 4 cycles; req_done pulses are never wider than 1 cycle.
REQ-034 reset=0 asserted during SECOND of a write -> outputs at reset values asynchronously, no req_done; a subsequent read completes normally.
REQ-035 With SRAM_BRIDGE_WAIT_EN defined, read at 0x3FFFE -> each half is held for 2 cycles, req_done 5 cycles after accept, req_rdata correct.
REQ-036 Bus ownership check -> data is never driven by the bridge while oute=0 or in IDLE/DONE.

Source files
------------

// File: rtl/sram_bridge.sv
// 32-bit request port to 16-bit asynchronous SRAM bridge: each word is two halfword accesses.
// Optional macro SRAM_BRIDGE_WAIT_EN stretches each halfword access to two cycles.
module sram_bridge #(
  parameter int ADDR_W    = 18,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_en,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       req_rdata,
  output logic              req_busy,
  output logic              req_done,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       data,
  output logic              wre,
  output logic              oute,
  output logic              chip_en,
  output logic              hb_mask,
  output logic              lb_mask
);

`ifdef SRAM_BRIDGE_WAIT_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, FIRST = 2'd1, SECOND = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state, w_next_state;
  logic                r_wait, r_rw;
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_wdata;
  logic [31:0]         r_req_rdata;
  logic                r_req_busy, r_req_done;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wre, r_oute, r_chip_en, r_mask;
  logic                r_data_oe;
  logic [15:0]         r_data_out;

  logic                w_phase_end, w_rw, w_active, w_hi, w_capture;
  logic [ADDR_W-1:0]   w_base, w_addr_n;
  logic [31:0]         w_wdata, w_rdata_n;
  logic [15:0]         w_dout_n;
  logic                w_unused;

  assign w_unused    = req_addr[0];
  assign w_phase_end = WAIT_EN ? r_wait : 1'b1;

  // State register plus request latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wait  <= 1'b0;
      r_rw    <= 1'b0;
      r_base  <= {ADDR_W{1'b0}};
      r_wdata <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      r_wait  <= ((r_state == FIRST || r_state == SECOND) && (w_next_state == r_state)) ? 1'b1 : 1'b0;
      if (r_state == IDLE && req_en) begin
        r_rw    <= req_rw;
        r_base  <= {req_addr[ADDR_W-1:1], 1'b0};
        r_wdata <= req_wdata;
      end else begin
        r_rw    <= r_rw;
        r_base  <= r_base;
        r_wdata <= r_wdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req_en) w_next_state = FIRST;  else w_next_state = IDLE;
      FIRST:   if (w_phase_end) w_next_state = SECOND; else w_next_state = FIRST;
      SECOND:  if (w_phase_end) w_next_state = DONE;   else w_next_state = SECOND;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Next output values, derived from the state being entered so outputs can be registered
  always_comb begin
    w_rw      = (r_state == IDLE) ? req_rw : r_rw;
    w_base    = (r_state == IDLE) ? {req_addr[ADDR_W-1:1], 1'b0} : r_base;
    w_wdata   = (r_state == IDLE) ? req_wdata : r_wdata;
    w_active  = (w_next_state == FIRST) || (w_next_state == SECOND);
    w_hi      = (w_next_state == FIRST) ? ~LOW_FIRST : LOW_FIRST;
    w_addr_n  = w_active ? (w_base | {{(ADDR_W-1){1'b0}}, w_hi}) : r_addr;
    w_dout_n  = w_hi ? w_wdata[31:16] : w_wdata[15:0];
    // The halfword now on the bus is identified by the registered address LSB
    w_capture = (r_state == FIRST || r_state == SECOND) && !r_rw && w_phase_end;
    w_rdata_n = r_req_rdata;
    if (w_capture) begin
      if (r_addr[0]) w_rdata_n[31:16] = data;
      else           w_rdata_n[15:0]  = data;
    end else begin
      w_rdata_n = r_req_rdata;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req_rdata <= 32'h0000_0000;
      r_req_busy  <= 1'b0;
      r_req_done  <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wre       <= 1'b1;
      r_oute      <= 1'b1;
      r_chip_en   <= 1'b1;
      r_mask      <= 1'b1;
      r_data_oe   <= 1'b0;
      r_data_out  <= 16'h0000;
    end else begin
      r_req_rdata <= w_rdata_n;
      r_req_busy  <= (w_next_state != IDLE);
      r_req_done  <= (w_next_state == DONE);
      r_addr      <= w_addr_n;
      r_wre       <= ~(w_active & w_rw);
      r_oute      <= ~(w_active & ~w_rw);
      r_chip_en   <= ~w_active;
      r_mask      <= ~w_active;
      r_data_oe   <= w_active & w_rw;
      r_data_out  <= w_dout_n;
    end
  end

  assign req_rdata = r_req_rdata;
  assign req_busy  = r_req_busy;
  assign req_done  = r_req_done;
  assign addr      = r_addr;
  assign wre       = r_wre;
  assign oute      = r_oute;
  assign chip_en   = r_chip_en;
  assign hb_mask   = r_mask;
  assign lb_mask   = r_mask;
  assign data      = r_data_oe ? r_data_out : 16'hzzzz;

endmodule
